// File: rtl/mem0_stage.sv
// MEM0 stage: consumes the EX->MEM0 latch, issues one data-bus request per
// memory instruction, checks alignment and forms byte strobes / lane data.
module mem0_stage #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   input  logic                is_load_i,
   input  logic                is_store_i,
   input  logic [1:0]          size_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic                flush_i,
   input  logic                ctl_mem1_allow_in_i,
   input  logic                data_addr_ok_i,
   output logic                data_req_o,
   output logic                data_wr_o,
   output logic [DATA_W/8-1:0] data_wstrb_o,
   output logic [ADDR_W-1:0]   data_addr_o,
   output logic [DATA_W-1:0]   data_wdata_o,
   output logic                ctl_mem0_over_o,
   output logic                ctl_mem_allow_in_o,
   output logic                mem0_excp_o
);

   localparam int STRB_W = DATA_W / 8;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic {
      ISSUE = 1'b0,
      HELD  = 1'b1
   } state_t;

   state_t state_reg;
   state_t state_next;

   logic mem_op;
   logic misalign;
   logic accepted;

   logic [STRB_W-1:0] strb_byte;
   logic [STRB_W-1:0] strb_half;
   logic [DATA_W-1:0] wdata_byte;
   logic [DATA_W-1:0] wdata_half;

   assign mem_op   = is_load_i | is_store_i;
   assign misalign = mem_op & ((size_i == 2'd3) |
                               ((size_i == SIZE_HALF) & addr_i[0]) |
                               ((size_i == SIZE_WORD) & (addr_i[1:0] != 2'b00)));

   // Lane replication: every byte/half lane carries the same store data so
   // the memory only needs the strobes to pick the right one.
   generate
      for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
         assign wdata_byte[gi*8 +: 8] = wdata_i[7:0];
         assign wdata_half[gi*8 +: 8] = wdata_i[(gi % 2)*8 +: 8];
      end
   endgenerate

   assign strb_byte = STRB_W'(1) << addr_i[1:0];
   assign strb_half = STRB_W'(3) << addr_i[1:0];

   always_comb begin
      data_wstrb_o = '0;
      data_wdata_o = wdata_i;
      case (size_i)
         SIZE_BYTE: begin
            data_wstrb_o = strb_byte;
            data_wdata_o = wdata_byte;
         end
         SIZE_HALF: begin
            data_wstrb_o = strb_half;
            data_wdata_o = wdata_half;
         end
         SIZE_WORD: begin
            data_wstrb_o = '1;
            data_wdata_o = wdata_i;
         end
         default: begin
            data_wstrb_o = '0;
            data_wdata_o = wdata_i;
         end
      endcase
      if (!is_store_i) begin
         data_wstrb_o = '0;
      end
   end

   assign data_addr_o = {addr_i[ADDR_W-1:2], 2'b00};
   assign data_wr_o   = is_store_i;

   // A request is only ever raised from ISSUE; once accepted, HELD keeps the
   // same instruction from issuing twice while the downstream stalls.
   assign data_req_o = (state_reg == ISSUE) & valid_i & mem_op & !misalign & !flush_i;
   assign accepted   = data_req_o & data_addr_ok_i;

   assign ctl_mem0_over_o = valid_i & (flush_i | !mem_op | misalign |
                                       (state_reg == HELD) | accepted);
   assign ctl_mem_allow_in_o = !valid_i | (ctl_mem0_over_o & ctl_mem1_allow_in_i);
   assign mem0_excp_o        = valid_i & misalign & !flush_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= ISSUE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ISSUE: begin
            if (accepted && !ctl_mem1_allow_in_i) begin
               state_next = HELD;
            end
         end
         HELD: begin
            if (ctl_mem1_allow_in_i) begin
               state_next = ISSUE;
            end
         end
         default: state_next = ISSUE;
      endcase
   end

endmodule

// File: tb/tb_mem0_stage.sv
// Directed bench for mem0_stage: expected outputs are queued when a step is
// driven and popped/compared once the combinational outputs settle.
module tb_mem0_stage;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              valid_i;
   logic              is_load_i;
   logic              is_store_i;
   logic [1:0]        size_i;
   logic [ADDR_W-1:0] addr_i;
   logic [DATA_W-1:0] wdata_i;
   logic              flush_i;
   logic              ctl_mem1_allow_in_i;
   logic              data_addr_ok_i;
   logic              data_req_o;
   logic              data_wr_o;
   logic [3:0]        data_wstrb_o;
   logic [ADDR_W-1:0] data_addr_o;
   logic [DATA_W-1:0] data_wdata_o;
   logic              ctl_mem0_over_o;
   logic              ctl_mem_allow_in_o;
   logic              mem0_excp_o;

   typedef struct packed {
      logic        req;
      logic        wr;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        over;
      logic        allow;
      logic        excp;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk_i = ~clk_i;

   mem0_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .valid_i             (valid_i),
      .is_load_i           (is_load_i),
      .is_store_i          (is_store_i),
      .size_i              (size_i),
      .addr_i              (addr_i),
      .wdata_i             (wdata_i),
      .flush_i             (flush_i),
      .ctl_mem1_allow_in_i (ctl_mem1_allow_in_i),
      .data_addr_ok_i      (data_addr_ok_i),
      .data_req_o          (data_req_o),
      .data_wr_o           (data_wr_o),
      .data_wstrb_o        (data_wstrb_o),
      .data_addr_o         (data_addr_o),
      .data_wdata_o        (data_wdata_o),
      .ctl_mem0_over_o     (ctl_mem0_over_o),
      .ctl_mem_allow_in_o  (ctl_mem_allow_in_o),
      .mem0_excp_o         (mem0_excp_o)
   );

   task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   // Drive one cycle's inputs at the falling edge and queue the expectation.
   task automatic drive(input logic rst, input logic v, input logic ld, input logic st,
                        input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input logic fl, input logic m1, input logic ok, input exp_t e);
      @(negedge clk_i);
      rst_i = rst; valid_i = v; is_load_i = ld; is_store_i = st; size_i = sz;
      addr_i = a; wdata_i = wd; flush_i = fl; ctl_mem1_allow_in_i = m1;
      data_addr_ok_i = ok;
      exp_q.push_back(e);
   endtask

   task automatic check(input string tag);
      exp_t e;
      #2;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, observed req=%b expected an entry", tag, data_req_o);
         return;
      end
      e = exp_q.pop_front();
      $display("step %-12s req=%b wr=%b strb=%h addr=%h wdata=%h over=%b allow=%b excp=%b",
               tag, data_req_o, data_wr_o, data_wstrb_o, data_addr_o, data_wdata_o,
               ctl_mem0_over_o, ctl_mem_allow_in_o, mem0_excp_o);
      cmp({tag, ".req"},   32'(data_req_o),         32'(e.req));
      cmp({tag, ".wr"},    32'(data_wr_o),          32'(e.wr));
      cmp({tag, ".wstrb"}, 32'(data_wstrb_o),       32'(e.wstrb));
      cmp({tag, ".addr"},  data_addr_o,             e.addr);
      cmp({tag, ".wdata"}, data_wdata_o,            e.wdata);
      cmp({tag, ".over"},  32'(ctl_mem0_over_o),    32'(e.over));
      cmp({tag, ".allow"}, 32'(ctl_mem_allow_in_o), 32'(e.allow));
      cmp({tag, ".excp"},  32'(mem0_excp_o),        32'(e.excp));
   endtask

   // exp_t field order: req, wr, wstrb, addr, wdata, over, allow, excp
   initial begin
      rst_i = 1'b1; valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; size_i = 2'd0;
      addr_i = '0; wdata_i = '0; flush_i = 1'b0; ctl_mem1_allow_in_i = 1'b1;
      data_addr_ok_i = 1'b0;

      // Reset, idle
      drive(1, 0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0, '{0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 0});
      check("reset");
      drive(0, 0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0, '{0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 0});
      check("idle");

      // Word load accepted immediately
      drive(0, 1, 1, 0, 2'd2, 32'h1000, 32'h0, 0, 1, 1, '{1, 0, 4'h0, 32'h1000, 32'h0, 1, 1, 0});
      check("ld_w");

      // Byte store, addr_ok delayed three cycles
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 1, 2'd0, 32'h1003, 32'hAB, 0, 1, 0,
               '{1, 1, 4'h8, 32'h1000, 32'hABABABAB, 0, 0, 0});
         check("st_b_wait");
      end
      drive(0, 1, 0, 1, 2'd0, 32'h1003, 32'hAB, 0, 1, 1,
            '{1, 1, 4'h8, 32'h1000, 32'hABABABAB, 1, 1, 0});
      check("st_b_acc");

      // Half store accepted while downstream stalls -> HELD
      drive(0, 1, 0, 1, 2'd1, 32'h2002, 32'h1234, 0, 0, 1,
            '{1, 1, 4'hC, 32'h2000, 32'h12341234, 1, 0, 0});
      check("st_h_acc");
      drive(0, 1, 0, 1, 2'd1, 32'h2002, 32'h1234, 0, 0, 1,
            '{0, 1, 4'hC, 32'h2000, 32'h12341234, 1, 0, 0});
      check("st_h_held");
      drive(0, 1, 0, 1, 2'd1, 32'h2002, 32'h1234, 0, 1, 1,
            '{0, 1, 4'hC, 32'h2000, 32'h12341234, 1, 1, 0});
      check("st_h_rel");

      // Misaligned word load and reserved size
      drive(0, 1, 1, 0, 2'd2, 32'h1002, 32'h0, 0, 1, 1, '{0, 0, 4'h0, 32'h1000, 32'h0, 1, 1, 1});
      check("ld_w_mis");
      drive(0, 1, 1, 0, 2'd3, 32'h1000, 32'h0, 0, 1, 1, '{0, 0, 4'h0, 32'h1000, 32'h0, 1, 1, 1});
      check("ld_size3");
      drive(0, 1, 0, 1, 2'd1, 32'h2001, 32'h55AA, 0, 1, 1,
            '{0, 1, 4'h6, 32'h2000, 32'h55AA55AA, 1, 1, 1});
      check("st_h_mis");

      // Non-memory instruction completes with no request
      drive(0, 1, 0, 0, 2'd2, 32'h1000, 32'h0, 0, 1, 1, '{0, 0, 4'h0, 32'h1000, 32'h0, 1, 1, 0});
      check("nonmem");

      // Store waiting on addr_ok, then flushed
      drive(0, 1, 0, 1, 2'd2, 32'h3000, 32'hDEADBEEF, 0, 1, 0,
            '{1, 1, 4'hF, 32'h3000, 32'hDEADBEEF, 0, 0, 0});
      check("st_w_wait");
      drive(0, 1, 0, 1, 2'd2, 32'h3000, 32'hDEADBEEF, 1, 1, 0,
            '{0, 1, 4'hF, 32'h3000, 32'hDEADBEEF, 1, 1, 0});
      check("st_w_flush");

      // Flush while HELD: access stands, instruction still completes
      drive(0, 1, 0, 1, 2'd0, 32'h3001, 32'h5C, 0, 0, 1,
            '{1, 1, 4'h2, 32'h3000, 32'h5C5C5C5C, 1, 0, 0});
      check("st_b_acc2");
      drive(0, 1, 0, 1, 2'd0, 32'h3001, 32'h5C, 1, 1, 0,
            '{0, 1, 4'h2, 32'h3000, 32'h5C5C5C5C, 1, 1, 0});
      check("held_flush");

      // Back-to-back loads, zero bubble
      drive(0, 1, 1, 0, 2'd2, 32'h0, 32'h0, 0, 1, 1, '{1, 0, 4'h0, 32'h0, 32'h0, 1, 1, 0});
      check("b2b_0");
      drive(0, 1, 1, 0, 2'd2, 32'h4, 32'h0, 0, 1, 1, '{1, 0, 4'h0, 32'h4, 32'h0, 1, 1, 0});
      check("b2b_4");

      // Reset while HELD
      drive(0, 1, 0, 1, 2'd2, 32'h40, 32'h11223344, 0, 0, 1,
            '{1, 1, 4'hF, 32'h40, 32'h11223344, 1, 0, 0});
      check("st_w_acc");
      drive(1, 1, 0, 1, 2'd2, 32'h40, 32'h11223344, 0, 0, 0,
            '{0, 1, 4'hF, 32'h40, 32'h11223344, 1, 0, 0});
      check("rst_held");
      drive(0, 0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, '{0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 0});
      check("post_rst");
      drive(0, 1, 0, 1, 2'd2, 32'h40, 32'h11223344, 0, 0, 0,
            '{1, 1, 4'hF, 32'h40, 32'h11223344, 0, 0, 0});
      check("reissue");

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
